// File: rtl/mips_new.sv
// Multicycle MIPS-subset datapath with externally sequenced phases (count_state).
// PC, instruction ROM, IR, 32x32 register file, ALU and data RAM; bring-up core without a controller.
module mips_new #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned ROM_VARIANT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            count_state,
    output logic [DATA_WIDTH-1:0] dbg_pc,
    output logic [DATA_WIDTH-1:0] dbg_instr,
    output logic [DATA_WIDTH-1:0] dbg_rd1,
    output logic [DATA_WIDTH-1:0] dbg_rd2,
    output logic [DATA_WIDTH-1:0] dbg_alu_out
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXECUTE   = 4'd3,
        ST_WRITEBACK = 4'd4
    } phase_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [DATA_WIDTH-1:0] pc_q, ir_q, a_q, b_q, alu_q;
    logic [DATA_WIDTH-1:0] rf_q  [32];
    logic [DATA_WIDTH-1:0] ram_q [2**ADDR_WIDTH];

    phase_e                phase;
    logic [5:0]            opcode, funct;
    logic [4:0]            rs, rt, rd;
    logic [DATA_WIDTH-1:0] imm_sext, src2, alu_d, rom_data;
    logic [ADDR_WIDTH-1:0] rom_addr, ram_addr;
    logic                  rf_we, ram_we;
    logic [4:0]            rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    assign phase    = phase_e'(count_state);
    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{(DATA_WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    assign rom_addr = pc_q[ADDR_WIDTH+1:2];
    assign ram_addr = alu_q[ADDR_WIDTH+1:2];

    // Variant 1 exercises negative operands, slt/sub wrap, logic ops, sw/lw and unknown encodings.
    function automatic logic [31:0] rom_word(input logic [ADDR_WIDTH-1:0] addr);
        int unsigned idx;
        idx = int'(addr);
        rom_word = '0;
        if (ROM_VARIANT == 0) begin
            case (idx)
                0: rom_word = 32'h21080001;
                1: rom_word = 32'h21290004;
                2: rom_word = 32'h214a000a;
                3: rom_word = 32'h216b00ff;
                4: rom_word = 32'h218c0002;
                5: rom_word = 32'h01288820;
                6: rom_word = 32'h022a9020;
                default: rom_word = '0;
            endcase
        end else begin
            case (idx)
                0:  rom_word = 32'h2001FFFF;
                1:  rom_word = 32'h20020001;
                2:  rom_word = 32'h0022182A;
                3:  rom_word = 32'h20040002;
                4:  rom_word = 32'h00442822;
                5:  rom_word = 32'hAC050004;
                6:  rom_word = 32'h8C060004;
                7:  rom_word = 32'h00223824;
                8:  rom_word = 32'h00224025;
                9:  rom_word = 32'h00221827;
                10: rom_word = 32'h3C091234;
                default: rom_word = '0;
            endcase
        end
    endfunction

    assign rom_data = DATA_WIDTH'(rom_word(rom_addr));

    always_comb begin
        src2  = (opcode == OP_RTYPE) ? b_q : imm_sext;
        alu_d = '0;
        case (opcode)
            OP_ADDI, OP_LW, OP_SW: alu_d = a_q + src2;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_d = a_q + src2;
                    FN_SUB:  alu_d = a_q - src2;
                    FN_AND:  alu_d = a_q & src2;
                    FN_OR:   alu_d = a_q | src2;
                    FN_SLT:  alu_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(src2))};
                    default: alu_d = '0;
                endcase
            end
            default: alu_d = '0;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = alu_q;
        ram_we   = 1'b0;
        case (opcode)
            OP_ADDI: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
            end
            OP_LW: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = ram_q[ram_addr];
            end
            OP_SW: ram_we = 1'b1;
            OP_RTYPE: begin
                rf_waddr = rd;
                rf_we    = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                           (funct == FN_OR)  || (funct == FN_SLT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= '0;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (phase)
                ST_FETCH: begin
                    ir_q <= rom_data;
                    pc_q <= pc_q + DATA_WIDTH'(4);
                end
                ST_DECODE: begin
                    a_q <= rf_q[rs];
                    b_q <= rf_q[rt];
                end
                ST_EXECUTE: alu_q <= alu_d;
                ST_WRITEBACK: begin
                    if (rf_we && (rf_waddr != 5'd0)) begin
                        rf_q[rf_waddr] <= rf_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data RAM has no reset; a store is suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && (phase == ST_WRITEBACK) && ram_we) begin
            ram_q[ram_addr] <= b_q;
        end
    end

    assign dbg_pc      = pc_q;
    assign dbg_instr   = ir_q;
    assign dbg_rd1     = a_q;
    assign dbg_rd2     = b_q;
    assign dbg_alu_out = alu_q;

endmodule

// File: tb/tb_mips_new.sv
// Scoreboard bench for mips_new: an ISA-level model pushes expected values per phase,
// which are popped and compared against the DUT after the clock edge.
module tb_mips_new;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  cs0 = '0, cs1 = '0;
    logic [31:0] pc0, ir0, a0, b0, alu0;
    logic [31:0] pc1, ir1, a1, b1, alu1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned sel      = 0;

    always #5 clk = ~clk;

    mips_new #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .ROM_VARIANT(0)) dut0 (
        .clk(clk), .reset(reset), .count_state(cs0),
        .dbg_pc(pc0), .dbg_instr(ir0), .dbg_rd1(a0), .dbg_rd2(b0), .dbg_alu_out(alu0)
    );

    mips_new #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .ROM_VARIANT(1)) dut1 (
        .clk(clk), .reset(reset), .count_state(cs1),
        .dbg_pc(pc1), .dbg_instr(ir1), .dbg_rd1(a1), .dbg_rd2(b1), .dbg_alu_out(alu1)
    );

    typedef struct {
        int unsigned kind;   // 0 pc, 1 ir, 2 A, 3 B, 4 ALUOut, 5 register
        int unsigned idx;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_pc, m_ir, m_a, m_b, m_alu;
    logic [31:0] m_rf [32];
    logic [31:0] m_ram [int];

    function automatic logic [31:0] prog_word(input int unsigned which, input int unsigned idx);
        logic [31:0] p0 [7]  = '{32'h21080001, 32'h21290004, 32'h214a000a, 32'h216b00ff,
                                 32'h218c0002, 32'h01288820, 32'h022a9020};
        logic [31:0] p1 [11] = '{32'h2001FFFF, 32'h20020001, 32'h0022182A, 32'h20040002,
                                 32'h00442822, 32'hAC050004, 32'h8C060004, 32'h00223824,
                                 32'h00224025, 32'h00221827, 32'h3C091234};
        if (which == 0) return (idx < 7)  ? p0[idx] : 32'h0;
        return (idx < 11) ? p1[idx] : 32'h0;
    endfunction

    function automatic logic [31:0] obs(input int unsigned kind, input int unsigned idx);
        logic [4:0] r;
        r = idx[4:0];
        if (sel == 0) begin
            case (kind)
                0: return pc0;
                1: return ir0;
                2: return a0;
                3: return b0;
                4: return alu0;
                default: return dut0.rf_q[r];
            endcase
        end
        case (kind)
            0: return pc1;
            1: return ir1;
            2: return a1;
            3: return b1;
            4: return alu1;
            default: return dut1.rf_q[r];
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, expv);
        end
    endtask

    function automatic void push(input int unsigned kind, input int unsigned idx,
                                 input logic [31:0] val, input string tag);
        exp_t e;
        e.kind = kind; e.idx = idx; e.val = val; e.tag = tag;
        exp_q.push_back(e);
    endfunction

    function automatic void push_dbg(input string pfx);
        push(0, 0, m_pc,  {pfx, "_pc"});
        push(1, 0, m_ir,  {pfx, "_ir"});
        push(2, 0, m_a,   {pfx, "_a"});
        push(3, 0, m_b,   {pfx, "_b"});
        push(4, 0, m_alu, {pfx, "_alu"});
    endfunction

    function automatic void model_wr(input logic [4:0] r, input logic [31:0] v, input string pfx);
        if (r != 5'd0) m_rf[r] = v;
        push(5, r, m_rf[r], $sformatf("%s_r%0d", pfx, r));
    endfunction

    function automatic void model_phase(input int unsigned ph);
        logic [5:0]  op, fn;
        logic [31:0] imm, src;
        string       pfx;
        op  = m_ir[31:26];
        fn  = m_ir[5:0];
        imm = {{16{m_ir[15]}}, m_ir[15:0]};
        src = (op == 6'h00) ? m_b : imm;
        pfx = $sformatf("pc%0h_ph%0d", m_pc, ph);
        case (ph)
            1: begin
                m_ir = prog_word(sel, int'(m_pc[9:2]));
                m_pc = m_pc + 32'd4;
            end
            2: begin
                m_a = m_rf[m_ir[25:21]];
                m_b = m_rf[m_ir[20:16]];
            end
            3: begin
                if (op == 6'h08 || op == 6'h23 || op == 6'h2B) m_alu = m_a + imm;
                else if (op == 6'h00) begin
                    case (fn)
                        6'h20:   m_alu = m_a + src;
                        6'h22:   m_alu = m_a - src;
                        6'h24:   m_alu = m_a & src;
                        6'h25:   m_alu = m_a | src;
                        6'h2A:   m_alu = ($signed(m_a) < $signed(src)) ? 32'd1 : 32'd0;
                        default: m_alu = 32'd0;
                    endcase
                end else m_alu = 32'd0;
            end
            4: begin
                if (op == 6'h08) model_wr(m_ir[20:16], m_alu, pfx);
                else if (op == 6'h23) model_wr(m_ir[20:16],
                    m_ram.exists(int'(m_alu[9:2])) ? m_ram[int'(m_alu[9:2])] : 32'h0, pfx);
                else if (op == 6'h2B) m_ram[int'(m_alu[9:2])] = m_b;
                else if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                                         fn == 6'h25 || fn == 6'h2A))
                    model_wr(m_ir[15:11], m_alu, pfx);
            end
            default: ;
        endcase
        push_dbg(pfx);
    endfunction

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(e.tag, obs(e.kind, e.idx), e.val);
        end
    endtask

    task automatic drive_cs(input int unsigned ph);
        if (sel == 0) begin cs0 = 4'(ph); cs1 = '0; end
        else          begin cs1 = 4'(ph); cs0 = '0; end
    endtask

    task automatic do_phase(input int unsigned ph);
        model_phase(ph);
        drive_cs(ph);
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic do_reset(input int unsigned ph);
        m_pc = '0; m_ir = '0; m_a = '0; m_b = '0; m_alu = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        push_dbg("rst");
        for (int i = 0; i < 32; i++) push(5, i, 32'h0, $sformatf("rst_r%0d", i));
        reset = 1'b0;
        drive_cs(ph);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_cs(0);
        drain();
    endtask

    task automatic run_instr(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            for (int unsigned p = 1; p <= 4; p++) do_phase(p);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 0;
        do_reset(0);

        // main program with idle/out-of-range holds in the middle of instruction 4
        run_instr(3);
        do_phase(1);
        do_phase(2);
        repeat (3) do_phase(0);
        repeat (2) do_phase(7);
        do_phase(3);
        do_phase(4);
        run_instr(3);
        check_eq("final_r8",  obs(5, 8),  32'h1);
        check_eq("final_r9",  obs(5, 9),  32'h4);
        check_eq("final_r10", obs(5, 10), 32'h0A);
        check_eq("final_r11", obs(5, 11), 32'hFF);
        check_eq("final_r12", obs(5, 12), 32'h2);
        check_eq("final_r17", obs(5, 17), 32'h5);
        check_eq("final_r18", obs(5, 18), 32'h0F);
        check_eq("final_pc",  obs(0, 0),  32'h1C);

        // reset during EXECUTE of the third instruction
        do_reset(0);
        run_instr(2);
        do_phase(1);
        do_phase(2);
        do_reset(3);
        do_phase(1);
        check_eq("after_rst_ir", obs(1, 0), 32'h21080001);
        check_eq("after_rst_pc", obs(0, 0), 32'h4);

        // variant ROM: signed slt, sub wrap, logic ops, store/load, unknown funct/opcode
        sel = 1;
        do_reset(0);
        run_instr(11);
        check_eq("v_slt_r3", obs(5, 3), 32'h1);
        check_eq("v_sub_r5", obs(5, 5), 32'hFFFFFFFF);
        check_eq("v_lw_r6",  obs(5, 6), 32'hFFFFFFFF);
        check_eq("v_and_r7", obs(5, 7), 32'h1);
        check_eq("v_or_r8",  obs(5, 8), 32'hFFFFFFFF);
        check_eq("v_unk_r9", obs(5, 9), 32'h0);
        check_eq("v_unk_alu", obs(4, 0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
